sdram_slot_arbiter: RTL and testbench



---
 rtl/sdram_arb_pkg.sv | 40 ++++
 rtl/sdram_arb_pick.sv | 44 ++++
 rtl/sdram_slot_arbiter.sv | 140 ++++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and constants for the SDRAM slot arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

    localparam int PORT_LOADER = 0;
    localparam int PORT_VIDEO  = 1;
    localparam int PORT_CPU    = 2;
    localparam int NPORTS      = 3;

    localparam int REQ_ADDR_W  = 20;
    localparam int REQ_DATA_W  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic [1:0]            ds;
    } req_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NPORTS-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[PORT_VIDEO]) idx = 2'd1;
        if (oh[PORT_CPU])   idx = 2'd2;
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_arb_pick.sv
// ============================================================================
// Module      : sdram_arb_pick
// Description : Combinational winner select. Port 0 always wins; ports 1/2
//               alternate when SDRAM_ARB_RR_EN is defined, else fixed 1 > 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic              ptr,
    output logic [NPORTS-1:0] grant,
    output logic              valid
);

`ifndef SDRAM_ARB_RR_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ptr;
`endif

    always_comb begin
        grant = '0;
        if (req[PORT_LOADER]) begin
            grant[PORT_LOADER] = 1'b1;
`ifdef SDRAM_ARB_RR_EN
        end else if (req[PORT_VIDEO] && req[PORT_CPU]) begin
            // ptr = 0 favours video, ptr = 1 favours CPU
            if (ptr) grant[PORT_CPU]   = 1'b1;
            else     grant[PORT_VIDEO] = 1'b1;
`endif
        end else if (req[PORT_VIDEO]) begin
            grant[PORT_VIDEO] = 1'b1;
        end else if (req[PORT_CPU]) begin
            grant[PORT_CPU] = 1'b1;
        end
    end

    assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/sdram_slot_arbiter.sv
// ============================================================================
// Module      : sdram_slot_arbiter
// Description : Grants one of three requesters per SDRAM sync slot and routes
//               read data back. Optional macro: SDRAM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_ds,
    output logic              p0_ack,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_ds,
    output logic              p1_ack,
    output logic              p1_rvalid,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_wdata,
    input  logic [1:0]        p2_ds,
    output logic              p2_ack,
    output logic              p2_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic [1:0]        ram_ds,
    input  logic [DATA_W-1:0] ram_dout
);

    req_t              w_req [NPORTS];
    req_t              w_sel;
    logic [NPORTS-1:0] w_req_bits;
    logic [NPORTS-1:0] w_grant;
    logic              w_valid;
    logic              w_ptr;

    slot_state_t       r_state;
    logic [1:0]        r_owner;
    logic              r_is_read;
    logic [NPORTS-1:0] r_ack;
    logic [NPORTS-1:0] r_rvalid;

    assign w_req[PORT_LOADER] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, ds: p0_ds};
    assign w_req[PORT_VIDEO]  = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, ds: p1_ds};
    assign w_req[PORT_CPU]    = '{we: p2_we, addr: p2_addr, wdata: p2_wdata, ds: p2_ds};
    assign w_req_bits         = {p2_req, p1_req, p0_req};

`ifdef SDRAM_ARB_RR_EN
    logic r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    sdram_arb_pick u_pick (
        .req   (w_req_bits),
        .ptr   (w_ptr),
        .grant (w_grant),
        .valid (w_valid)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_grant[i]) w_sel = w_req[i];
        end
    end

    always_ff @(posedge clk) begin
        r_ack    <= '0;
        r_rvalid <= '0;
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= 2'd0;
            r_is_read <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_ds    <= 2'b00;
            rdata     <= '0;
`ifdef SDRAM_ARB_RR_EN
            r_ptr     <= 1'b0;
`endif
        end else if (sync) begin
            // Retiring the old slot and starting the new one are independent
            if (r_state == BUSY && r_is_read) begin
                rdata             <= ram_dout;
                r_rvalid[r_owner] <= 1'b1;
            end
            if (w_valid) begin
                r_state   <= BUSY;
                r_owner   <= onehot_to_idx(w_grant);
                r_is_read <= ~w_sel.we;
                r_ack     <= w_grant;
                ram_we    <= w_sel.we;
                ram_oe    <= ~w_sel.we;
                ram_addr  <= w_sel.addr;
                ram_din   <= w_sel.wdata;
                ram_ds    <= w_sel.ds;
`ifdef SDRAM_ARB_RR_EN
                if (w_grant[PORT_VIDEO]) r_ptr <= 1'b1;
                if (w_grant[PORT_CPU])   r_ptr <= 1'b0;
`endif
            end else begin
                r_state <= IDLE;
                ram_we  <= 1'b0;
                ram_oe  <= 1'b0;
            end
        end
    end

    assign p0_ack    = r_ack[PORT_LOADER];
    assign p1_ack    = r_ack[PORT_VIDEO];
    assign p2_ack    = r_ack[PORT_CPU];
    assign p0_rvalid = r_rvalid[PORT_LOADER];
    assign p1_rvalid = r_rvalid[PORT_VIDEO];
    assign p2_rvalid = r_rvalid[PORT_CPU];

endmodule

`default_nettype wire

// File: tb/tb_sdram_slot_arbiter.sv
// ============================================================================
// Module      : tb_sdram_slot_arbiter
// Description : Directed self-checking bench for sdram_slot_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_slot_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sync;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, p2_req = 0, p2_we = 0;
    logic [19:0] p0_addr = 0, p1_addr = 0, p2_addr = 0;
    logic [15:0] p0_wdata = 0, p1_wdata = 0, p2_wdata = 0;
    logic [1:0]  p0_ds = 0, p1_ds = 0, p2_ds = 0;
    logic        p0_ack, p1_ack, p2_ack, p0_rvalid, p1_rvalid, p2_rvalid;
    logic [15:0] rdata, ram_din, ram_dout;
    logic        ram_we, ram_oe;
    logic [19:0] ram_addr;
    logic [1:0]  ram_ds;

    logic [2:0]  slot_cnt = 3'd0;
    logic [15:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) slot_cnt <= slot_cnt + 3'd1;
    assign sync = (slot_cnt == 3'd7);

    // SDRAM model: read data is whatever the addressed word holds during the slot
    always @(posedge clk) if (ram_we) mem[ram_addr[7:0]] <= ram_din;
    assign ram_dout = ram_oe ? mem[ram_addr[7:0]] : 16'h0000;

    sdram_slot_arbiter dut (
        .clk(clk), .reset(reset), .sync(sync),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ds(p0_ds),
        .p0_ack(p0_ack), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ds(p1_ds),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid),
        .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata), .p2_ds(p2_ds),
        .p2_ack(p2_ack), .p2_rvalid(p2_rvalid),
        .rdata(rdata), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_ds(ram_ds), .ram_dout(ram_dout)
    );

    // Lands on the negedge just before a sync posedge
    task automatic to_sync;
        int n;
        n = 0;
        @(negedge clk);
        while (sync !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        p0_req = 0; p1_req = 0; p2_req = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        p0_req = 1; p0_we = 1; p0_addr = 20'h00033; p0_wdata = 16'h5555; p0_ds = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ({p0_ack, p1_ack, p2_ack, p0_rvalid, p1_rvalid, p2_rvalid, ram_we, ram_oe} !== 8'h00) begin
                errors++;
                $display("FAIL reset_ctrl cyc%0d: got %b want 00000000", i,
                         {p0_ack, p1_ack, p2_ack, p0_rvalid, p1_rvalid, p2_rvalid, ram_we, ram_oe});
            end
        end
        checks++;
        if ({ram_addr, ram_din, rdata, ram_ds} !== 54'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h din=%h rdata=%h ds=%b want all zero",
                     ram_addr, ram_din, rdata, ram_ds);
        end
        p0_req = 0; p0_we = 0;
        reset = 1'b0;
    endtask

    task automatic test_idle;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            checks++;
            if ({p0_ack, p1_ack, p2_ack, p0_rvalid, p1_rvalid, p2_rvalid, ram_we, ram_oe} !== 8'h00) begin
                errors++;
                $display("FAIL idle cyc%0d: got %b want 00000000", i,
                         {p0_ack, p1_ack, p2_ack, p0_rvalid, p1_rvalid, p2_rvalid, ram_we, ram_oe});
            end
        end
    endtask

    task automatic test_loader_write;
        do_reset();
        to_sync();
        p0_req = 1; p0_we = 1; p0_addr = 20'h00010; p0_wdata = 16'hBEEF; p0_ds = 2'b11;
        @(negedge clk);
        checks++;
        if ({p0_ack, ram_we, ram_oe, ram_addr, ram_din, ram_ds} !== {1'b1, 1'b1, 1'b0, 20'h00010, 16'hBEEF, 2'b11}) begin
            errors++;
            $display("FAIL lw_grant: ack=%b we=%b oe=%b addr=%h din=%h ds=%b want 1 1 0 00010 beef 11",
                     p0_ack, ram_we, ram_oe, ram_addr, ram_din, ram_ds);
        end
        p0_req = 0; p0_we = 0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({p0_ack, ram_we, ram_din, p0_rvalid, p1_rvalid, p2_rvalid} !== {1'b0, 1'b1, 16'hBEEF, 3'b000}) begin
                errors++;
                $display("FAIL lw_hold cyc%0d: ack=%b we=%b din=%h rv=%b%b%b want 0 1 beef 000",
                         i, p0_ack, ram_we, ram_din, p0_rvalid, p1_rvalid, p2_rvalid);
            end
        end
        @(negedge clk);
        checks++;
        if ({ram_we, ram_oe, ram_din, ram_addr, p0_rvalid} !== {1'b0, 1'b0, 16'hBEEF, 20'h00010, 1'b0}) begin
            errors++;
            $display("FAIL lw_after: we=%b oe=%b din=%h addr=%h rv=%b want 0 0 beef 00010 0",
                     ram_we, ram_oe, ram_din, ram_addr, p0_rvalid);
        end
    endtask

    task automatic test_cpu_read;
        do_reset();
        to_sync();
        p2_req = 1; p2_we = 0; p2_addr = 20'h00010; p2_ds = 2'b11;
        @(negedge clk);
        checks++;
        if ({p2_ack, ram_oe, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 20'h00010}) begin
            errors++;
            $display("FAIL rd_grant: ack=%b oe=%b we=%b addr=%h want 1 1 0 00010",
                     p2_ack, ram_oe, ram_we, ram_addr);
        end
        p2_req = 0;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (p2_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL rd_early cyc%0d: rvalid=%b want 0", i, p2_rvalid);
            end
        end
        @(negedge clk);
        checks++;
        if ({p2_rvalid, p1_rvalid, p0_rvalid, rdata} !== {3'b100, 16'hBEEF}) begin
            errors++;
            $display("FAIL rd_data: rv210=%b%b%b rdata=%h want 100 beef",
                     p2_rvalid, p1_rvalid, p0_rvalid, rdata);
        end
        @(negedge clk);
        checks++;
        if ({p2_rvalid, rdata} !== {1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL rd_hold: rvalid=%b rdata=%h want 0 beef", p2_rvalid, rdata);
        end
    endtask

    task automatic test_contention;
        logic [2:0] exp [4];
`ifdef SDRAM_ARB_RR_EN
        exp[0] = 3'b010; exp[1] = 3'b100; exp[2] = 3'b010; exp[3] = 3'b100;
`else
        exp[0] = 3'b010; exp[1] = 3'b010; exp[2] = 3'b010; exp[3] = 3'b010;
`endif
        do_reset();
        p0_we = 0; p1_we = 0; p2_we = 0;
        p0_addr = 20'h00001; p1_addr = 20'h00002; p2_addr = 20'h00003;
        p0_req = 1; p1_req = 1; p2_req = 1;
        for (int s = 0; s < 3; s++) begin
            to_sync();
            @(negedge clk);
            checks++;
            if ({p2_ack, p1_ack, p0_ack} !== 3'b001) begin
                errors++;
                $display("FAIL cont_p0 slot%0d: ack210=%b want 001", s, {p2_ack, p1_ack, p0_ack});
            end
        end
        p0_req = 0;
        for (int s = 0; s < 4; s++) begin
            to_sync();
            @(negedge clk);
            checks++;
            if ({p2_ack, p1_ack, p0_ack} !== exp[s]) begin
                errors++;
                $display("FAIL cont_12 slot%0d: ack210=%b want %b", s, {p2_ack, p1_ack, p0_ack}, exp[s]);
            end
        end
        p1_req = 0; p2_req = 0;
    endtask

    task automatic test_back_to_back;
        do_reset();
        to_sync();
        p1_req = 1; p1_we = 0; p1_addr = 20'h00010;
        @(negedge clk);
        checks++;
        if (p1_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_p1_ack: got %b want 1", p1_ack);
        end
        p1_req = 0;
        p2_req = 1; p2_we = 0; p2_addr = 20'h00011;
        to_sync();
        @(negedge clk);
        checks++;
        if ({p1_rvalid, p2_ack, p2_rvalid, rdata} !== {1'b1, 1'b1, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL b2b_overlap: p1_rv=%b p2_ack=%b p2_rv=%b rdata=%h want 1 1 0 beef",
                     p1_rvalid, p2_ack, p2_rvalid, rdata);
        end
        p2_req = 0;
        to_sync();
        @(negedge clk);
        checks++;
        if ({p2_rvalid, p1_rvalid, rdata} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL b2b_p2_data: p2_rv=%b p1_rv=%b rdata=%h want 1 0 0000",
                     p2_rvalid, p1_rvalid, rdata);
        end
    endtask

    task automatic test_reset_mid_read;
        do_reset();
        to_sync();
        p2_req = 1; p2_we = 0; p2_addr = 20'h00010; p2_ds = 2'b01;
        @(negedge clk);
        checks++;
        if ({p2_ack, ram_oe} !== 2'b11) begin
            errors++;
            $display("FAIL mid_grant: ack=%b oe=%b want 1 1", p2_ack, ram_oe);
        end
        p2_req = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({p2_ack, p2_rvalid, ram_we, ram_oe, ram_addr, ram_din, rdata, ram_ds} !== 58'd0) begin
            errors++;
            $display("FAIL mid_reset_vals: ack=%b rv=%b we=%b oe=%b addr=%h din=%h rdata=%h ds=%b want zeros",
                     p2_ack, p2_rvalid, ram_we, ram_oe, ram_addr, ram_din, rdata, ram_ds);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++;
            if ({p0_rvalid, p1_rvalid, p2_rvalid, ram_oe, ram_we} !== 5'b00000) begin
                errors++;
                $display("FAIL mid_after cyc%0d: rv=%b%b%b oe=%b we=%b want 00000",
                         i, p0_rvalid, p1_rvalid, p2_rvalid, ram_oe, ram_we);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        test_reset();
        test_idle();
        test_loader_write();
        test_cpu_read();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
